if_id_queue: RTL

//   Parametrised IF->ID boundary with valid/ready handshakes on both sides and a

---
 rtl/if_id_queue.sv | 96 +++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// IF->ID boundary queue: a DEPTH-entry first-word-fall-through buffer of {pc, instr} pairs with
// valid/ready on both sides, flush on redirect, and NOP presentation when empty.
module if_id_queue #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 2,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [PC_WIDTH-1:0]      if_pc_in,
  input  logic [INSTR_WIDTH-1:0]   if_instr_in,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [PC_WIDTH-1:0]      id_pc_out,
  output logic [INSTR_WIDTH-1:0]   id_instr_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic full;
  logic empty;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);

  // Ready depends only on occupancy and flush, never on id_ready.
  assign if_ready = ~full & ~flush;
  assign id_valid = ~empty;

  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only resident entries are ever presented.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= if_pc_in;
      instr_mem[wr_ptr_q] <= if_instr_in;
    end
  end

  always_comb begin
    id_pc_out    = '0;
    id_instr_out = NOP_INSTR;
    if (id_valid) begin
      id_pc_out    = pc_mem[rd_ptr_q];
      id_instr_out = instr_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule
